alu_result_serializer: RTL and testbench

- Downstream consumer of the ALU result path. Captures each registered ALU result (data plus valid pulse) into a holding register.
- Splits the result into BYTE_WIDTH-wide bytes and writes them one per cycle into the UART TX FIFO, obeying the FIFO full flag.
- Flags results that arrive while a previous result is still being sent (overrun).

---
 rtl/alu_result_serializer.sv | 119 +++++++++++
 tb/tb_alu_result_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_serializer.sv
// Serializes each captured ALU result into BYTE_WIDTH bytes for the UART TX FIFO,
// honouring FIFO_FULL and flagging results that arrive while a frame is in flight.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no frame pending; waiting for OUT_VALID
// S_SEND | presenting hold bytes to the FIFO, one per non-full cycle
module alu_result_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  OUT_VALID,
    input  logic                  FIFO_FULL,
    input  logic                  CLR_OVR,
    output logic [BYTE_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERRUN
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (NB > 2) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    generate
        if ((DATA_WIDTH % BYTE_WIDTH) != 0 || NB < 2) begin : g_param_check
            $error("alu_result_serializer: DATA_WIDTH must be a multiple of BYTE_WIDTH with at least 2 bytes");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  done_q;
    logic                  ovr_q;

    logic                  byte_ok;
    logic                  last_ok;
    logic                  take_new;
    logic                  ovr_evt;
    logic [IDX_W-1:0]      sel;
    logic [BYTE_WIDTH-1:0] byte_sel;

    // A new result is only safe to take when nothing is in flight after this edge.
    assign byte_ok  = (state_q == S_SEND) && !FIFO_FULL;
    assign last_ok  = byte_ok && (idx_q == LAST_IDX);
    assign take_new = OUT_VALID && ((state_q == S_IDLE) || last_ok);
    assign ovr_evt  = OUT_VALID && (state_q == S_SEND) && !last_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (OUT_VALID) state_d = S_SEND;
            S_SEND: if (last_ok) state_d = OUT_VALID ? S_SEND : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            done_q <= last_ok;
            if (take_new) begin
                hold_q <= ALU_OUT;
                idx_q  <= '0;
            end else if (last_ok) begin
                idx_q  <= '0;
            end else if (byte_ok) begin
                idx_q  <= idx_q + IDX_W'(1);
            end
            if (ovr_evt) begin
                ovr_q <= 1'b1;
            end else if (CLR_OVR) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // MSB-first mirrors the index rather than the data so one mux serves both orders.
    always_comb begin
        sel      = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
        byte_sel = '0;
        for (int i = 0; i < NB; i++) begin
            if (sel == IDX_W'(i)) byte_sel = hold_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_comb begin
        TX_VALID = byte_ok;
        BUSY     = (state_q == S_SEND);
        TX_DATA  = (state_q == S_SEND) ? byte_sel : '0;
        DONE     = done_q;
        OVERRUN  = ovr_q;
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: LSB-first and MSB-first instances share stimulus;
// per-cycle table checks plus a scoreboard of expected FIFO writes per instance.
module tb_alu_result_serializer;

    logic        clk;
    logic        rst;
    logic [15:0] alu_out;
    logic        out_valid;
    logic        fifo_full;
    logic        clr_ovr;

    logic [7:0]  tx_data_l, tx_data_m;
    logic        tx_valid_l, tx_valid_m;
    logic        busy_l, busy_m;
    logic        done_l, done_m;
    logic        overrun_l, overrun_m;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    logic [7:0] q_lsb[$];
    logic [7:0] q_msb[$];

    typedef struct {
        logic [15:0] alu;
        logic [7:0]  lsb0;
        logic [7:0]  lsb1;
        logic [7:0]  msb0;
        logic [7:0]  msb1;
    } vec_t;

    vec_t vecs[6];

    alu_result_serializer #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .CLK(clk), .RST(rst), .ALU_OUT(alu_out), .OUT_VALID(out_valid),
        .FIFO_FULL(fifo_full), .CLR_OVR(clr_ovr),
        .TX_DATA(tx_data_l), .TX_VALID(tx_valid_l), .BUSY(busy_l),
        .DONE(done_l), .OVERRUN(overrun_l)
    );

    alu_result_serializer #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .CLK(clk), .RST(rst), .ALU_OUT(alu_out), .OUT_VALID(out_valid),
        .FIFO_FULL(fifo_full), .CLR_OVR(clr_ovr),
        .TX_DATA(tx_data_m), .TX_VALID(tx_valid_m), .BUSY(busy_m),
        .DONE(done_m), .OVERRUN(overrun_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [15:0] v);
        q_lsb.push_back(v[7:0]);
        q_lsb.push_back(v[15:8]);
        q_msb.push_back(v[15:8]);
        q_msb.push_back(v[7:0]);
    endfunction

    task automatic pulse(input logic [15:0] v, input bit push);
        alu_out   = v;
        out_valid = 1'b1;
        if (push) push_frame(v);
        @(posedge clk); #1;
        out_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Scoreboard: every accepted FIFO write must match the next expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid_l) begin
                n_writes++;
                if (q_lsb.size() == 0) check("sb_lsb_unexpected_write", {24'h0, tx_data_l}, 32'hFFFF_FFFF);
                else check("sb_lsb_byte", {24'h0, tx_data_l}, {24'h0, q_lsb.pop_front()});
            end
            if (tx_valid_m) begin
                if (q_msb.size() == 0) check("sb_msb_unexpected_write", {24'h0, tx_data_m}, 32'hFFFF_FFFF);
                else check("sb_msb_byte", {24'h0, tx_data_m}, {24'h0, q_msb.pop_front()});
            end
        end
    end

    initial begin
        int w0;
        vecs[0] = '{16'hA55A, 8'h5A, 8'hA5, 8'hA5, 8'h5A};
        vecs[1] = '{16'h1234, 8'h34, 8'h12, 8'h12, 8'h34};
        vecs[2] = '{16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{16'h00FF, 8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[5] = '{16'h8001, 8'h01, 8'h80, 8'h80, 8'h01};

        rst = 1'b1; alu_out = '0; out_valid = 1'b0; fifo_full = 1'b0; clr_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_tx_valid", {31'h0, tx_valid_l}, 0);
        check("rst_tx_data",  {24'h0, tx_data_l}, 0);
        check("rst_busy",     {31'h0, busy_l}, 0);
        check("rst_done",     {31'h0, done_l}, 0);
        check("rst_overrun",  {31'h0, overrun_l}, 0);
        step();
        check("idle_tx_valid", {31'h0, tx_valid_l}, 0);

        for (int i = 0; i < 6; i++) begin
            pulse(vecs[i].alu, 1'b1);
            check("vec_b0_valid", {31'h0, tx_valid_l}, 1);
            check("vec_b0_lsb",   {24'h0, tx_data_l}, {24'h0, vecs[i].lsb0});
            check("vec_b0_msb",   {24'h0, tx_data_m}, {24'h0, vecs[i].msb0});
            check("vec_b0_done",  {31'h0, done_l}, 0);
            step();
            check("vec_b1_valid", {31'h0, tx_valid_l}, 1);
            check("vec_b1_lsb",   {24'h0, tx_data_l}, {24'h0, vecs[i].lsb1});
            check("vec_b1_msb",   {24'h0, tx_data_m}, {24'h0, vecs[i].msb1});
            step();
            check("vec_done",     {31'h0, done_l}, 1);
            check("vec_busy_end", {31'h0, busy_l}, 0);
            check("vec_idle_valid", {31'h0, tx_valid_l}, 0);
            check("vec_idle_data",  {24'h0, tx_data_l}, 0);
            step();
            check("vec_done_pulse", {31'h0, done_l}, 0);
        end

        // Stall after the first byte for 4 cycles.
        w0 = n_writes;
        pulse(16'hBEEF, 1'b1);
        check("stall_b0", {24'h0, tx_data_l}, 32'hEF);
        step();
        fifo_full = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("stall_no_write", {31'h0, tx_valid_l}, 0);
            check("stall_busy", {31'h0, busy_l}, 1);
            step();
        end
        fifo_full = 1'b0;
        #1;
        check("stall_b1_valid", {31'h0, tx_valid_l}, 1);
        check("stall_b1", {24'h0, tx_data_l}, 32'hBE);
        step();
        check("stall_done", {31'h0, done_l}, 1);
        check("stall_writes", n_writes - w0, 2);
        step();

        // Back-to-back: second result lands on the edge that accepts the last byte.
        pulse(16'h0102, 1'b1);
        check("b2b_b0", {24'h0, tx_data_l}, 32'h02);
        step();
        check("b2b_b1", {24'h0, tx_data_l}, 32'h01);
        pulse(16'h0304, 1'b1);
        check("b2b_no_gap", {31'h0, tx_valid_l}, 1);
        check("b2b_b2", {24'h0, tx_data_l}, 32'h04);
        check("b2b_done1", {31'h0, done_l}, 1);
        step();
        check("b2b_b3", {24'h0, tx_data_l}, 32'h03);
        check("b2b_mid_done", {31'h0, done_l}, 0);
        step();
        check("b2b_done2", {31'h0, done_l}, 1);
        check("b2b_overrun", {31'h0, overrun_l}, 0);
        step();

        // Overrun while first byte is stalled.
        fifo_full = 1'b1;
        pulse(16'hCAFE, 1'b1);
        check("ovr_stalled", {31'h0, tx_valid_l}, 0);
        pulse(16'h1111, 1'b0);
        check("ovr_set", {31'h0, overrun_l}, 1);
        check("ovr_set_msb", {31'h0, overrun_m}, 1);
        fifo_full = 1'b0;
        #1;
        check("ovr_b0", {24'h0, tx_data_l}, 32'hFE);
        step();
        check("ovr_b1", {24'h0, tx_data_l}, 32'hCA);
        step();
        check("ovr_done", {31'h0, done_l}, 1);
        check("ovr_sticky", {31'h0, overrun_l}, 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_cleared", {31'h0, overrun_l}, 0);

        pulse(16'h5566, 1'b1);
        alu_out = 16'h2222; out_valid = 1'b1; clr_ovr = 1'b1;
        step();
        out_valid = 1'b0; clr_ovr = 1'b0;
        check("ovr_set_wins", {31'h0, overrun_l}, 1);
        check("ovr_frame_cont", {24'h0, tx_data_l}, 32'h55);
        step();
        check("ovr_frame_done", {31'h0, done_l}, 1);
        step();

        // Asynchronous reset mid-frame.
        pulse(16'h1357, 1'b1);
        check("mrst_pre_valid", {31'h0, tx_valid_l}, 1);
        #2 rst = 1'b1;
        #1;
        check("mrst_tx_valid", {31'h0, tx_valid_l}, 0);
        check("mrst_tx_data",  {24'h0, tx_data_l}, 0);
        check("mrst_busy",     {31'h0, busy_l}, 0);
        check("mrst_overrun",  {31'h0, overrun_l}, 0);
        check("mrst_msb_valid", {31'h0, tx_valid_m}, 0);
        q_lsb.delete();
        q_msb.delete();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mrst_no_write", {31'h0, tx_valid_l}, 0);
        end

        check("sb_lsb_drained", q_lsb.size(), 0);
        check("sb_msb_drained", q_msb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
